lfsr_stream_gen: RTL

Parametrised pseudo-random sequence generator: a WIDTH-bit LFSR with run-time Fibonacci/Galois selection, seed loading, a valid/ready output handshake, all-zero lockup detection and sequence-period measurement. It is the general-purpose successor to the team's fixed 16-bit Fibonacci LFSR. It feeds test-pattern, scrambler and BIST datapaths that need backpressure-aware random words.

---
 rtl/lfsr_stream_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/lfsr_stream_gen.sv
// Parametrised LFSR word generator: run-time Fibonacci/Galois stepping, seed load,
// valid/ready output, all-zero lockup detection and sequence-period measurement.
module lfsr_stream_gen #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] FIB_TAPS   = WIDTH'(16'h050A),
    parameter logic [WIDTH-1:0] GAL_POLY   = WIDTH'(16'h002D),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(16'hFFFF),
    parameter int unsigned      CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             lockup,
    output logic             period_done,
    output logic [CNT_W-1:0] period
);

    typedef enum logic [1:0] {IDLE, RUN, LOCKED} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pd_d;
    logic             fire_c;
    logic [WIDTH-1:0] step_c;

    assign fire_c = (fsm_q == RUN) & out_ready & enable;

    // One LFSR step in the currently selected structure
    always_comb begin
        if (mode)
            step_c = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? GAL_POLY : '0);
        else
            step_c = {state_q[WIDTH-2:0], ^(state_q & FIB_TAPS)};
    end

    // Next-state logic; load outranks any fire in the same cycle
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        ref_d    = ref_q;
        count_d  = count_q;
        period_d = period_q;
        pd_d     = 1'b0;
        if (load) begin
            state_d = seed;
            ref_d   = seed;
            count_d = '0;
            fsm_d   = (seed != '0) ? RUN : LOCKED;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (enable)
                        fsm_d = (state_q != '0) ? RUN : LOCKED;
                end
                RUN: begin
                    if (fire_c) begin
                        state_d = step_c;
                        if (step_c == ref_q) begin
                            period_d = count_q + CNT_W'(1);
                            count_d  = '0;
                            pd_d     = 1'b1;
                        end else begin
                            count_d  = count_q + CNT_W'(1);
                        end
                        if (step_c == '0)
                            fsm_d = LOCKED;
                    end
                end
                LOCKED: ;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= IDLE;
            state_q     <= RESET_SEED;
            ref_q       <= RESET_SEED;
            count_q     <= '0;
            period_q    <= '0;
            period_done <= 1'b0;
            out_valid   <= 1'b0;
            lockup      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            ref_q       <= ref_d;
            count_q     <= count_d;
            period_q    <= period_d;
            period_done <= pd_d;
            out_valid   <= (fsm_d == RUN);
            lockup      <= (fsm_d == LOCKED);
        end
    end

    assign out    = state_q;
    assign period = period_q;

endmodule
